// File: rtl/dff_deser_pkg.sv
// Shared types and defaults for the q/q_bar word deserializer.
// Parity helper is used only when DESER_PARITY_EN is defined.
package dff_deser_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } deser_state_e;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 8;
  localparam int PAR_MAX_W = 64;

  // Even parity over a zero-extended word.
  function automatic logic even_parity(input logic [PAR_MAX_W-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/dff_deser_fifo.sv
// Synchronous show-ahead FIFO holding assembled words (plus parity when enabled).
// Depth must be a power of two so the pointers wrap naturally.
module dff_deser_fifo
  import dff_deser_pkg::*;
#(
  parameter int DW    = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] push_data,
  output logic [DW-1:0] head_data,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DW-1:0] mem_r [DEPTH];
  logic [PW-1:0] rd_ptr_r;
  logic [PW-1:0] wr_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_pop_s;
  logic          do_push_s;

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {DW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= {DW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign head_data = mem_r[rd_ptr_r];
  assign full      = (count_r == CW'(DEPTH));
  assign empty     = (count_r == {CW{1'b0}});

endmodule

// File: rtl/dff_q_deserializer.sv
// Packs q samples LSB-first into WIDTH-bit words queued behind a valid/ready port.
// Optional DESER_PARITY_EN adds word_par (even parity of the head word).
module dff_q_deserializer
  import dff_deser_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     bit_en,
  input  logic                     q,
  input  logic                     q_bar,
  output logic [WIDTH-1:0]         word_data,
  output logic                     word_valid,
  input  logic                     word_ready,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic                     overflow,
  output logic [CNT_W-1:0]         drop_cnt,
`ifdef DESER_PARITY_EN
  output logic                     word_par,
`endif
  output logic                     comp_err
);

  localparam int BC_W = $clog2(WIDTH);
`ifdef DESER_PARITY_EN
  localparam int DW = WIDTH + 1;
`else
  localparam int DW = WIDTH;
`endif

  deser_state_e     state_r;
  logic [BC_W-1:0]  bit_cnt_r;
  logic [WIDTH-2:0] shift_r;
  logic             comp_err_r;
  logic             overflow_r;
  logic [CNT_W-1:0] drop_cnt_r;

  logic             complete_s;
  logic [WIDTH-1:0] word_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic             full_s;
  logic             empty_s;
  logic [DW-1:0]    push_data_s;
  logic [DW-1:0]    head_s;

  // The incoming bit is the MSB of the finished word; earlier bits have shifted down.
  assign word_s     = {q, shift_r};
  assign complete_s = bit_en && (bit_cnt_r == BC_W'(WIDTH - 1));
  assign pop_s      = !empty_s && word_ready;
  assign push_s     = complete_s && (!full_s || pop_s);
  assign drop_s     = complete_s && full_s && !pop_s;

`ifdef DESER_PARITY_EN
  assign push_data_s = {even_parity(PAR_MAX_W'(word_s)), word_s};
  assign word_par    = head_s[WIDTH];
`else
  assign push_data_s = word_s;
`endif

  // Bit-collection FSM and shifter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      bit_cnt_r <= {BC_W{1'b0}};
      shift_r   <= {(WIDTH-1){1'b0}};
    end else if (clear) begin
      state_r   <= IDLE;
      bit_cnt_r <= {BC_W{1'b0}};
      shift_r   <= {(WIDTH-1){1'b0}};
    end else if (bit_en) begin
      shift_r <= word_s[WIDTH-1:1];
      case (state_r)
        IDLE: begin
          state_r   <= FILL;
          bit_cnt_r <= BC_W'(1);
        end
        FILL: begin
          if (complete_s) begin
            state_r   <= IDLE;
            bit_cnt_r <= {BC_W{1'b0}};
          end else begin
            state_r   <= FILL;
            bit_cnt_r <= bit_cnt_r + BC_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          bit_cnt_r <= {BC_W{1'b0}};
        end
      endcase
    end
  end

  // Sticky integrity/overflow flags and saturating drop counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      comp_err_r <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
    end else if (clear) begin
      comp_err_r <= 1'b0;
      overflow_r <= 1'b0;
      drop_cnt_r <= {CNT_W{1'b0}};
    end else begin
      if (bit_en && (q == q_bar)) begin
        comp_err_r <= 1'b1;
      end
      if (drop_s) begin
        overflow_r <= 1'b1;
        if (drop_cnt_r != {CNT_W{1'b1}}) begin
          drop_cnt_r <= drop_cnt_r + CNT_W'(1);
        end
      end
    end
  end

  dff_deser_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (push_data_s),
    .head_data (head_s),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign word_data  = head_s[WIDTH-1:0];
  assign word_valid = !empty_s;
  assign bit_cnt    = bit_cnt_r;
  assign overflow   = overflow_r;
  assign drop_cnt   = drop_cnt_r;
  assign comp_err   = comp_err_r;

endmodule

// File: tb/tb_dff_q_deserializer.sv
// Self-checking bench for dff_q_deserializer (WIDTH=8, DEPTH=2): vector table,
// directed corner sequences and random traffic against a queue-based model.
module tb_dff_q_deserializer;

  localparam int WIDTH = 8;
  localparam int DEPTH = 2;
  localparam int CNT_W = 8;

  logic       clk = 1'b0;
  logic       rst, clear, bit_en, q, q_bar, word_ready;
  logic [7:0] word_data;
  logic       word_valid;
  logic [2:0] bit_cnt;
  logic       overflow;
  logic [7:0] drop_cnt;
  logic       comp_err;
`ifdef DESER_PARITY_EN
  logic       word_par;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dff_q_deserializer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .bit_en     (bit_en),
    .q          (q),
    .q_bar      (q_bar),
    .word_data  (word_data),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .bit_cnt    (bit_cnt),
    .overflow   (overflow),
    .drop_cnt   (drop_cnt),
`ifdef DESER_PARITY_EN
    .word_par   (word_par),
`endif
    .comp_err   (comp_err)
  );

  // Reference model: a word queue plus a partial word built bit by bit.
  logic [7:0] mq[$];
  int         k_m;
  logic [7:0] acc_m;
  logic       ov_m, cerr_m;
  int         drop_m;

  function automatic void model_reset();
    mq.delete();
    k_m = 0; acc_m = 8'h00; ov_m = 1'b0; cerr_m = 1'b0; drop_m = 0;
  endfunction

  function automatic void model_edge(input logic en, qi, qbi, rdy, clr);
    if (clr) begin
      model_reset();
    end else begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (en) begin
        if (qi == qbi) cerr_m = 1'b1;
        acc_m[k_m] = qi;
        k_m++;
        if (k_m == WIDTH) begin
          if (mq.size() < DEPTH) mq.push_back(acc_m);
          else begin
            ov_m = 1'b1;
            if (drop_m < 255) drop_m++;
          end
          k_m = 0;
          acc_m = 8'h00;
        end
      end
    end
  endfunction

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void check_model();
    chk("valid", word_valid, mq.size() > 0);
    if (mq.size() > 0) begin
      chk("data", word_data, mq[0]);
`ifdef DESER_PARITY_EN
      chk("word_par", word_par, ^mq[0]);
`endif
    end
    chk("bit_cnt", bit_cnt, k_m);
    chk("overflow", overflow, ov_m);
    chk("drop_cnt", drop_cnt, drop_m);
    chk("comp_err", comp_err, cerr_m);
  endfunction

  function automatic void check_zero(input string tag);
    chk({tag, "_valid"}, word_valid, 0);
    chk({tag, "_data"}, word_data, 0);
    chk({tag, "_bit_cnt"}, bit_cnt, 0);
    chk({tag, "_overflow"}, overflow, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
    chk({tag, "_comp_err"}, comp_err, 0);
`ifdef DESER_PARITY_EN
    chk({tag, "_word_par"}, word_par, 0);
`endif
  endfunction

  task automatic step(input logic en, qi, qbi, rdy, clr);
    bit_en = en; q = qi; q_bar = qbi; word_ready = rdy; clear = clr;
    @(posedge clk);
    model_edge(en, qi, qbi, rdy, clr);
    #1;
    check_model();
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy);
    for (int i = 0; i < WIDTH; i++) step(1'b1, w[i], ~w[i], rdy, 1'b0);
  endtask

  typedef struct {
    logic       en;
    logic       qi;
    logic       rdy;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t       tbl[10];
  logic [7:0] pat;
  logic [7:0] w44;
  logic       rq;

  initial begin
    rst = 1'b0; clear = 1'b0; bit_en = 1'b0; q = 1'b0; q_bar = 1'b1; word_ready = 1'b0;
    model_reset();
    #12;
    check_zero("reset");
    rst = 1'b1;

    // 8'h8D LSB-first with ready high: visible exactly one cycle after the 8th bit.
    pat = 8'h8D;
    for (int i = 0; i < 10; i++) begin
      tbl[i].en        = (i < 8);
      tbl[i].qi        = (i < 8) ? pat[i] : 1'b0;
      tbl[i].rdy       = 1'b1;
      tbl[i].exp_valid = (i == 7);
      tbl[i].exp_data  = 8'h8D;
      tbl[i].exp_cnt   = (i < 8) ? 3'((i + 1) % 8) : 3'd0;
    end
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].en, tbl[i].qi, ~tbl[i].qi, tbl[i].rdy, 1'b0);
      chk("tbl_valid", word_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) chk("tbl_data", word_data, tbl[i].exp_data);
      chk("tbl_bit_cnt", bit_cnt, tbl[i].exp_cnt);
      chk("tbl_comp_err", comp_err, 0);
    end

    // Overflow: third word dropped while ready is low, then drain in order.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    chk("ovf_flag", overflow, 1);
    chk("ovf_drop_cnt", drop_cnt, 1);
    chk("ovf_head_11", word_data, 8'h11);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ovf_head_22", word_data, 8'h22);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("ovf_empty", word_valid, 0);

    // Full FIFO, completing bit and pop on the same edge: no drop.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    w44 = 8'h44;
    for (int i = 0; i < 7; i++) step(1'b1, w44[i], ~w44[i], 1'b0, 1'b0);
    step(1'b1, w44[7], ~w44[7], 1'b1, 1'b0);
    chk("same_edge_overflow", overflow, 0);
    chk("same_edge_head", word_data, 8'h22);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("same_edge_next", word_data, 8'h44);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("same_edge_empty", word_valid, 0);

    // Complement violation on bit 3; data still taken from q, flag sticky until clear.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, pat[i], (i == 3) ? 1'b1 : ~pat[i], 1'b0, 1'b0);
    chk("cerr_flag", comp_err, 1);
    chk("cerr_data", word_data, 8'h8D);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("cerr_held", comp_err, 1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("cerr_cleared", comp_err, 0);

    // Asynchronous reset mid-word with flags and FIFO populated.
    send_word(8'h11, 1'b0);
    send_word(8'h22, 1'b0);
    send_word(8'h33, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_zero("midrst");
    #1 rst = 1'b1;
    send_word(8'hA5, 1'b1);
    chk("after_rst_data", word_data, 8'hA5);
`ifdef DESER_PARITY_EN
    chk("after_rst_par", word_par, 0);
`endif
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Drop counter saturates at all-ones.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < WIDTH * (DEPTH + 260); i++) begin
      rq = 1'($urandom_range(0, 1));
      step(1'b1, rq, ~rq, 1'b0, 1'b0);
    end
    chk("drop_saturated", drop_cnt, 8'hFF);

    // Random traffic against the model.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 3000; i++) begin
      rq = 1'($urandom_range(0, 1));
      step(($urandom % 4) != 0, rq, (($urandom % 16) == 0) ? rq : ~rq,
           1'($urandom_range(0, 1)), ($urandom % 200) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
